regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates byte writes from two requesters (0 = EU, 1 = BIU) into a
// register file that only accepts one nibble per cycle. Each accepted legal
// request becomes two write strobes: low nibble first (WR_LO), then high
// nibble (WR_HI). A new request may be accepted in WR_HI, so back-to-back
// traffic sustains one byte every two cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/addr/data  write request from requester N (addr 0..3 legal)
//   reqN_ready            combinational accept; valid&&ready = handshake
//   rf_write_enable       nibble write strobe (registered)
//   rf_write_addr         register index (registered, holds when idle)
//   rf_write_data         {4'h0, nibble} (registered, holds when idle)
//   rf_high_byte          0 = low nibble, 1 = high nibble
//   busy                  a write transaction is in flight
//   done                  pulse in the cycle the high nibble is written
//   err                   pulse the cycle after an illegal address is accepted
//   grant_id              requester owning the most recent acceptance
// -----------------------------------------------------------------------------
module regfile_write_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rf_write_enable,
    output logic [2:0] rf_write_addr,
    output logic [7:0] rf_write_data,
    output logic       rf_high_byte,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_req_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    wr_req_t    cap_q, cap_d;
    logic       rf_write_enable_q, rf_write_enable_d;
    logic [2:0] rf_write_addr_q, rf_write_addr_d;
    logic [7:0] rf_write_data_q, rf_write_data_d;
    logic       rf_high_byte_q, rf_high_byte_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       grant_id_q, grant_id_d;

    logic       can_accept;
    logic       win_id;
    logic       accept;
    logic       acc_legal;
    wr_req_t    acc_req;

    // Arbitration: a lone valid wins; on contention prio_q names the winner.
    // WR_LO cannot accept because its high nibble is still owed next cycle.
    always_comb begin
        can_accept = (state_q == IDLE) || (state_q == WR_HI);
        win_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        accept     = can_accept && (req0_valid || req1_valid);
        req0_ready = accept && !win_id;
        req1_ready = accept &&  win_id;
        acc_req    = win_id ? wr_req_t'{addr: req1_addr, data: req1_data}
                            : wr_req_t'{addr: req0_addr, data: req0_data};
        acc_legal  = !acc_req.addr[2];
    end

    // Next state and captured request.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        cap_d      = cap_q;
        grant_id_d = grant_id_q;
        err_d      = 1'b0;

        if (accept) begin
            // Favour the requester that lost (or did not take) this grant.
            prio_d     = ~win_id;
            grant_id_d = win_id;
            cap_d      = acc_req;
        end

        case (state_q)
            IDLE: begin
                if (accept && acc_legal) state_d = WR_LO;
                err_d = accept && !acc_legal;
            end
            WR_LO: state_d = WR_HI;
            WR_HI: begin
                state_d = (accept && acc_legal) ? WR_LO : IDLE;
                err_d   = accept && !acc_legal;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs derived from the state being entered, so the strobe for
    // a request appears exactly one cycle after its acceptance.
    always_comb begin
        rf_write_enable_d = (state_d != IDLE);
        rf_high_byte_d    = (state_d == WR_HI);
        done_d            = (state_d == WR_HI);
        busy_d            = (state_d != IDLE);
        rf_write_addr_d   = rf_write_addr_q;
        rf_write_data_d   = rf_write_data_q;
        case (state_d)
            WR_LO: begin
                rf_write_addr_d = cap_d.addr;
                rf_write_data_d = {4'h0, cap_d.data[3:0]};
            end
            WR_HI: begin
                rf_write_addr_d = cap_d.addr;
                rf_write_data_d = {4'h0, cap_d.data[7:4]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            prio_q            <= 1'b0;
            cap_q             <= '0;
            rf_write_enable_q <= 1'b0;
            rf_write_addr_q   <= 3'd0;
            rf_write_data_q   <= 8'd0;
            rf_high_byte_q    <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            err_q             <= 1'b0;
            grant_id_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            prio_q            <= prio_d;
            cap_q             <= cap_d;
            rf_write_enable_q <= rf_write_enable_d;
            rf_write_addr_q   <= rf_write_addr_d;
            rf_write_data_q   <= rf_write_data_d;
            rf_high_byte_q    <= rf_high_byte_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            err_q             <= err_d;
            grant_id_q        <= grant_id_d;
        end
    end

    assign rf_write_enable = rf_write_enable_q;
    assign rf_write_addr   = rf_write_addr_q;
    assign rf_write_data   = rf_write_data_q;
    assign rf_high_byte    = rf_high_byte_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign grant_id        = grant_id_q;

endmodule
